// File: rtl/tcp_tx_pkg.sv
// Shared definitions for the TCP transmit arbiter: FSM encoding and packet header layout.
package tcp_tx_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StPay  = 2'd2,
    StDisc = 2'd3
  } state_e;

  // Header is sync byte, channel id, payload length, sequence number.
  localparam int unsigned HdrLen = 4;

  localparam logic [1:0] HdrIdxSync = 2'd0;
  localparam logic [1:0] HdrIdxChan = 2'd1;
  localparam logic [1:0] HdrIdxLen  = 2'd2;
  localparam logic [1:0] HdrIdxSeq  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last grant, wrapping at N_CH.
module rr_arbiter #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [3:0]      last_i,
  output logic [3:0]      grant_o,
  output logic            valid_o
);

  logic [15:0] req_ext;

  assign req_ext = 16'(req_i);

  // Rotate the priority so the channel right after last_i is searched first.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    grant_o = '0;
    valid_o = 1'b0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      idx = 32'(last_i) + off;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!valid_o && req_ext[idx[3:0]]) begin
        grant_o = idx[3:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Round-robin packetiser sharing the SiTCP TX FIFO write port among N_CH producers.
// Each grant emits a 4-byte header then LEN payload bytes; payload is flushed on link loss.
module tcp_tx_arbiter
  import tcp_tx_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              CLK_200M,
  input  logic              SYS_RSTn,
  input  logic              LINK_UP,
  input  logic              FIFO_AFULL,
  input  logic [N_CH-1:0]   CH_REQ,
  input  logic [8*N_CH-1:0] CH_LEN,
  input  logic [8*N_CH-1:0] CH_DATA,
  output logic [N_CH-1:0]   CH_RD,
  output logic [7:0]        TX_DATA,
  output logic              TX_EN,
  output logic [3:0]        GRANT_ID,
  output logic              BUSY,
  output logic [7:0]        SEQ,
  output logic [15:0]       DROP_CNT
);

  state_e      state_q, state_d;
  logic [3:0]  g_q, g_d;
  logic [3:0]  rr_q, rr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] drop_q, drop_d;
  logic [3:0]  arb_grant;
  logic        arb_valid;
  logic        pop;

  // 16-entry views so a 4-bit channel index always selects in range.
  logic [7:0] len_arr  [16];
  logic [7:0] data_arr [16];

  for (genvar i = 0; i < 16; i++) begin : g_unpack
    if (i < N_CH) begin : g_used
      assign len_arr[i]  = CH_LEN[8*i +: 8];
      assign data_arr[i] = CH_DATA[8*i +: 8];
    end else begin : g_unused
      assign len_arr[i]  = 8'h00;
      assign data_arr[i] = 8'h00;
    end
  end

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_rr_arbiter (
    .req_i   (CH_REQ),
    .last_i  (rr_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  // State and datapath registers; rr starts at N_CH-1 so channel 0 wins first.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state_q   <= StIdle;
      g_q       <= '0;
      rr_q      <= 4'(N_CH - 1);
      len_q     <= '0;
      seq_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      hdr_idx_q <= HdrIdxSync;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      len_q     <= len_d;
      seq_q     <= seq_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      hdr_idx_q <= hdr_idx_d;
      drop_q    <= drop_d;
    end
  end

  // Next-state: grant, header emission, payload copy and discard flush.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    len_d     = len_q;
    seq_d     = seq_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    hdr_idx_d = hdr_idx_q;
    drop_d    = drop_q;
    case (state_q)
      StIdle: begin
        if (LINK_UP && arb_valid) begin
          g_d       = arb_grant;
          len_d     = len_arr[arb_grant];
          hdr_idx_d = HdrIdxSync;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        // Abort leaves SEQ and rr untouched so the same request is served again.
        if (!LINK_UP) begin
          state_d = StIdle;
        end else if (!FIFO_AFULL) begin
          tx_en_d = 1'b1;
          unique case (hdr_idx_q)
            HdrIdxSync: tx_data_d = HDR_BYTE;
            HdrIdxChan: tx_data_d = {4'b0000, g_q};
            HdrIdxLen:  tx_data_d = len_q;
            HdrIdxSeq:  tx_data_d = seq_q;
          endcase
          hdr_idx_d = 2'(hdr_idx_q + 2'd1);
          if (hdr_idx_q == 2'(HdrLen - 1)) begin
            seq_d = seq_q + 8'd1;
            if (len_q == 8'd0) begin
              state_d = StIdle;
              rr_d    = g_q;
            end else begin
              state_d = StPay;
            end
          end
        end
      end
      StPay: begin
        if (!LINK_UP) begin
          state_d = StDisc;
        end else if (!FIFO_AFULL) begin
          tx_en_d   = 1'b1;
          tx_data_d = data_arr[g_q];
          len_d     = len_q - 8'd1;
          if (len_q == 8'd1) begin
            state_d = StIdle;
            rr_d    = g_q;
          end
        end
      end
      StDisc: begin
        len_d = len_q - 8'd1;
        if (len_q == 8'd1) begin
          drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          state_d = StIdle;
          rr_d    = g_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: pop strobe to the granted producer and the busy flag.
  always_comb begin
    case (state_q)
      StPay:   pop = LINK_UP && !FIFO_AFULL;
      StDisc:  pop = 1'b1;
      default: pop = 1'b0;
    endcase
    BUSY = (state_q != StIdle);
    for (int i = 0; i < N_CH; i++) begin
      CH_RD[i] = pop && (g_q == 4'(i));
    end
  end

  assign TX_DATA  = tx_data_q;
  assign TX_EN    = tx_en_q;
  assign GRANT_ID = g_q;
  assign SEQ      = seq_q;
  assign DROP_CNT = drop_q;

endmodule

// File: doc/tcp_tx_arbiter.md
Name: tcp_tx_arbiter

Overview:
- Shares the single SiTCP TCP transmit path among N_CH data producers. It writes into the TCP TX FIFO write port, which feeds TCP_TX_DATA_IN, TCP_TX_EN_IN and FIFO_FULL.
- Round-robin arbitration; each grant emits one framed packet: 4-byte header, then LEN payload bytes.
- Write-side throttling follows the FIFO almost-full flag.
- Gated by TCP connection state (TCP_OPEN_ACK); payload of an in-flight packet is discarded cleanly if the connection drops.

Parameters:
- N_CH, 4, number of requesters (2..15).
- HDR_BYTE, 8'hA5, first header byte (sync marker).

Ports:
- CLK_200M  in  1  system clock, 200 MHz.
- SYS_RSTn  in  1  asynchronous, active-low reset.
- LINK_UP  in  1  TCP_OPEN_ACK from SiTCP; 1 = connection open.
- FIFO_AFULL  in  1  TX FIFO almost_full (FIFO_FULL).
- CH_REQ  in  N_CH  per-channel packet request; held until the channel's last CH_RD.
- CH_LEN  in  8*N_CH  per-channel payload length, channel i at [8i+7:8i]; 0 allowed.
- CH_DATA  in  8*N_CH  per-channel first-word-fall-through payload byte.
- CH_RD  out  N_CH  combinational pop strobe; one byte consumed per asserted cycle.
- TX_DATA  out  8  registered byte to FIFO din (TCP_TX_DATA_IN).
- TX_EN  out  1  registered FIFO wr_en (TCP_TX_EN_IN).
- GRANT_ID  out  4  index of the currently granted channel.
- BUSY  out  1  high whenever state != IDLE.
- SEQ  out  8  sequence number of the next packet.
- DROP_CNT  out  16  packets whose payload was discarded; saturates at 16'hFFFF.

Behaviour:
- Reset (SYS_RSTn=0, async): state=IDLE; all outputs 0; rr pointer = N_CH-1, so channel 0 has first priority.
- States: IDLE, HDR, PAY, DISC.
- IDLE:
  - If LINK_UP=1 and any CH_REQ=1: grant the first requesting channel searching from rr+1 modulo N_CH.
  - Latch g=index, L=CH_LEN[g], set hdr_idx=0, go to HDR.
  - Otherwise remain in IDLE.
- HDR: each cycle with FIFO_AFULL=0 and LINK_UP=1, write one byte and increment hdr_idx.
  - Header bytes in order: HDR_BYTE, {4'b0,g}, L, SEQ.
  - After byte 3: SEQ <= SEQ+1 (wraps 255->0). Go to PAY if L!=0; if L==0, go to IDLE and set rr <= g.
  - If FIFO_AFULL=1: no write, hold state.
- PAY: each cycle with FIFO_AFULL=0, in the same cycle:
  - Assert CH_RD[g].
  - Register TX_DATA<=CH_DATA[g] and TX_EN<=1; decrement L.
  - When L reaches 0: go to IDLE, set rr <= g.
  - If FIFO_AFULL=1: CH_RD=0, no write.
- Link drop:
  - LINK_UP=0 while in HDR: abort to IDLE with no payload popped; SEQ is not advanced; the request stays pending.
  - LINK_UP=0 while in PAY: go to DISC.
- DISC: assert CH_RD[g] every cycle regardless of FIFO_AFULL, with TX_EN=0, until L=0. Then DROP_CNT++ and go to IDLE; rr <= g.
- TX_EN and TX_DATA are registered: the byte decided in cycle n appears in cycle n+1. TX_EN is 0 on every non-write cycle.
- Latency: CH_REQ sampled in IDLE at cycle 0 -> HDR at cycle 1 -> first TX_EN at cycle 2, provided FIFO is not almost full.
- Throughput: 1 byte/cycle. Back-to-back packets incur exactly 1 IDLE cycle between them.
- A CH_REQ deasserted mid-packet is a protocol violation; the arbiter continues popping regardless.
- CH_LEN changes after grant are ignored.
- GRANT_ID is valid while BUSY=1 and holds its last value otherwise.

Decomposition:
- Shared package tcp_tx_pkg holds:
  - state encoding (IDLE/HDR/PAY/DISC);
  - HDR_LEN=4;
  - header byte index constants.
- One sub-module, rr_arbiter, takes N_CH request bits plus the last-grant pointer and returns the next grant (combinational priority rotate).

Test Plan:
- Single channel: ch1 requests LEN=3 with data 11,22,33, FIFO_AFULL=0. Required TX stream: A5,01,03,00,11,22,33 on 7 consecutive TX_EN cycles; SEQ ends at 1; CH_RD[1] pulses exactly 3 times.
- Fairness: all 4 channels request continuously with LEN=1. Grants go 0,1,2,3,0; there is exactly 1 idle cycle between packets; SEQ increments 0..4.
- Backpressure: FIFO_AFULL held high 5 cycles in the middle of payload byte 2 of a LEN=4 packet. No TX_EN and no CH_RD during those cycles; the byte order is preserved.
- LEN=0: ch2 requests. Required output is only A5,02,00,SEQ; CH_RD[2] is never asserted.
- Link drop: LINK_UP goes low after 2 of 10 payload bytes. TX_EN=0 thereafter; CH_RD stays high 8 more cycles; DROP_CNT=1; BUSY drops. No new grant occurs until LINK_UP=1.
- Reset mid-packet: SYS_RSTn asserted during PAY. All outputs are 0 immediately; after release, the arbiter starts from channel 0 with SEQ=0.
